// File: rtl/sm4_ctrl_pkg.sv
// SM4 round controller shared types: FSM state encoding, round count and
// round-key index helpers.
package sm4_ctrl_pkg;

  localparam int unsigned SM4_ROUNDS = 32;
  localparam int unsigned RK_IDX_W   = 5;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    KEY_EXP   = 3'd1,
    KEY_READY = 3'd2,
    ROUND     = 3'd3,
    DONE      = 3'd4
  } sm4_state_e;

  // Round-key select: rk[cnt] when encrypting, rk[31-cnt] when decrypting
  function automatic logic [RK_IDX_W-1:0] rk_index(input logic [RK_IDX_W-1:0] cnt,
                                                   input logic                dec);
    return dec ? (RK_IDX_W'(SM4_ROUNDS - 1) - cnt) : cnt;
  endfunction

endpackage

// File: rtl/sm4_round_counter.sv
// Round counter for the SM4 controller: synchronous clear, count enable,
// saturates at the last round and flags it (registered terminal flag).
module sm4_round_counter
  import sm4_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clr_i,
  input  logic                en_i,
  output logic [RK_IDX_W-1:0] cnt_o,
  output logic                term_o
);

  localparam logic [RK_IDX_W-1:0] LAST = RK_IDX_W'(SM4_ROUNDS - 1);

  logic [RK_IDX_W-1:0] cnt_q, cnt_d;
  logic                term_q;

  // Next count: clear wins, otherwise advance without wrapping past the last round
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + RK_IDX_W'(1);
    end
  end

  // Count and terminal-flag registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      term_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      term_q <= (cnt_d == LAST);
    end
  end

  assign cnt_o  = cnt_q;
  assign term_o = term_q;

endmodule

// File: rtl/sm4_round_ctrl.sv
// SM4 round controller: sequences key expansion, block acceptance, the 32
// rounds (round-key index per round) and the result handshake.
// Optional feature macro: SM4_DECRYPT_EN (when defined, decrypt_in reverses
// the round-key order; otherwise decrypt_in is ignored).
module sm4_round_ctrl
  import sm4_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                sm4_enable_in,
  input  logic                user_key_valid_in,
  output logic                key_exp_enable_out,
  output logic                key_exp_load_out,
  input  logic                key_exp_finished_in,
  input  logic                data_valid_in,
  output logic                data_ready_out,
  input  logic                decrypt_in,
  output logic                load_out,
  output logic                round_en_out,
  output logic [RK_IDX_W-1:0] rk_idx_out,
  output logic                data_valid_out,
  input  logic                data_ready_in,
  output logic                key_ready_out
);

  sm4_state_e          state_q, state_d;
  logic                dec_q, dec_d;
  logic                key_exp_en_q, key_exp_en_d;
  logic                key_load_q, key_load_d;
  logic                key_ready_q, key_ready_d;
  logic                data_ready_q, data_ready_d;
  logic                load_q, load_d;
  logic                round_en_q, round_en_d;
  logic [RK_IDX_W-1:0] rk_idx_q, rk_idx_d;
  logic                data_valid_q, data_valid_d;

  logic                cnt_clr, cnt_en, cnt_term;
  logic [RK_IDX_W-1:0] cnt;
  logic [RK_IDX_W-1:0] rk_sel;

  sm4_round_counter u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .cnt_o   (cnt),
    .term_o  (cnt_term)
  );

`ifdef SM4_DECRYPT_EN
  assign rk_sel = rk_index(cnt, dec_q);
`else
  // Mode latch is kept for the port contract but does not steer the index
  logic unused_dec;
  assign unused_dec = dec_q;
  assign rk_sel     = cnt;
`endif

  // Next state, counter control and next values of the registered outputs
  always_comb begin
    state_d    = state_q;
    dec_d      = dec_q;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    key_load_d = 1'b0;
    load_d     = 1'b0;
    round_en_d = 1'b0;
    rk_idx_d   = rk_idx_q;

    unique case (state_q)
      IDLE: begin
        if (user_key_valid_in) begin
          state_d    = KEY_EXP;
          key_load_d = 1'b1;
        end
      end
      KEY_EXP: begin
        if (key_exp_finished_in) begin
          state_d = KEY_READY;
        end
      end
      KEY_READY: begin
        // A new key takes priority over a block offered in the same cycle
        if (user_key_valid_in) begin
          state_d    = KEY_EXP;
          key_load_d = 1'b1;
        end else if (data_valid_in && data_ready_q) begin
          state_d = ROUND;
          load_d  = 1'b1;
          cnt_clr = 1'b1;
          dec_d   = decrypt_in;
        end
      end
      ROUND: begin
        round_en_d = 1'b1;
        rk_idx_d   = rk_sel;
        if (cnt_term) begin
          state_d = DONE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      DONE: begin
        if (data_valid_q && data_ready_in) begin
          state_d = KEY_READY;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Disable aborts everything and invalidates the key
    if (!sm4_enable_in) begin
      state_d    = IDLE;
      dec_d      = 1'b0;
      cnt_clr    = 1'b1;
      cnt_en     = 1'b0;
      key_load_d = 1'b0;
      load_d     = 1'b0;
      round_en_d = 1'b0;
      rk_idx_d   = '0;
    end

    key_exp_en_d = (state_d != IDLE);
    key_ready_d  = (state_d == KEY_READY) || (state_d == ROUND) || (state_d == DONE);
    data_ready_d = (state_d == KEY_READY);
    // Result valid from the second DONE cycle, after the last round has been applied
    data_valid_d = (state_d == DONE) && (state_q == DONE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      dec_q        <= 1'b0;
      key_exp_en_q <= 1'b0;
      key_load_q   <= 1'b0;
      key_ready_q  <= 1'b0;
      data_ready_q <= 1'b0;
      load_q       <= 1'b0;
      round_en_q   <= 1'b0;
      rk_idx_q     <= '0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dec_q        <= dec_d;
      key_exp_en_q <= key_exp_en_d;
      key_load_q   <= key_load_d;
      key_ready_q  <= key_ready_d;
      data_ready_q <= data_ready_d;
      load_q       <= load_d;
      round_en_q   <= round_en_d;
      rk_idx_q     <= rk_idx_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign key_exp_enable_out = key_exp_en_q;
  assign key_exp_load_out   = key_load_q;
  assign key_ready_out      = key_ready_q;
  assign data_ready_out     = data_ready_q;
  assign load_out           = load_q;
  assign round_en_out       = round_en_q;
  assign rk_idx_out         = rk_idx_q;
  assign data_valid_out     = data_valid_q;

endmodule

// File: tb/tb_sm4_round_ctrl.sv
// Self-checking bench for sm4_round_ctrl: key load, encrypt/decrypt block
// sequencing with a round-key scoreboard, result back-pressure, enable abort
// and asynchronous reset in the middle of the rounds.
module tb_sm4_round_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       sm4_enable_in = 1'b0;
  logic       user_key_valid_in = 1'b0;
  logic       key_exp_enable_out;
  logic       key_exp_load_out;
  logic       key_exp_finished_in = 1'b0;
  logic       data_valid_in = 1'b0;
  logic       data_ready_out;
  logic       decrypt_in = 1'b0;
  logic       load_out;
  logic       round_en_out;
  logic [4:0] rk_idx_out;
  logic       data_valid_out;
  logic       data_ready_in = 1'b0;
  logic       key_ready_out;

  always #5 clk = ~clk;

  sm4_round_ctrl dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .sm4_enable_in       (sm4_enable_in),
    .user_key_valid_in   (user_key_valid_in),
    .key_exp_enable_out  (key_exp_enable_out),
    .key_exp_load_out    (key_exp_load_out),
    .key_exp_finished_in (key_exp_finished_in),
    .data_valid_in       (data_valid_in),
    .data_ready_out      (data_ready_out),
    .decrypt_in          (decrypt_in),
    .load_out            (load_out),
    .round_en_out        (round_en_out),
    .rk_idx_out          (rk_idx_out),
    .data_valid_out      (data_valid_out),
    .data_ready_in       (data_ready_in),
    .key_ready_out       (key_ready_out)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;
  int unsigned load_cyc = 0;
  logic        dv_prev = 1'b0;
  logic [4:0]  rk_q[$];
  int unsigned lat_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({key_exp_enable_out, key_exp_load_out, load_out, round_en_out,
                rk_idx_out, data_valid_out, data_ready_out, key_ready_out});
  endfunction

  function automatic logic [4:0] exp_idx(input logic dec, input int r);
    logic use_dec;
    use_dec = dec;
`ifndef SM4_DECRYPT_EN
    use_dec = 1'b0;
`endif
    return use_dec ? 5'(31 - r) : 5'(r);
  endfunction

  // Monitor: pops the expected round-key index on every advancing round and
  // the expected latency when the result becomes valid
  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    if (load_out) load_cyc = cyc;
    if (round_en_out) begin
      if (rk_q.size() == 0) check("rk_extra", 32'd1, 32'd0);
      else check("rk_idx", 32'(rk_idx_out), 32'(rk_q.pop_front()));
    end
    if (data_valid_out && !dv_prev) begin
      if (lat_q.size() == 0) check("dv_extra", 32'd1, 32'd0);
      else check("latency", cyc - load_cyc, lat_q.pop_front());
    end
    dv_prev = data_valid_out;
  end

  task automatic load_key();
    key_exp_finished_in = 1'b0;
    user_key_valid_in   = 1'b1;
    step();
    user_key_valid_in = 1'b0;
    check("key_load_pulse", 32'(key_exp_load_out), 32'd1);
    check("key_exp_en", 32'(key_exp_enable_out), 32'd1);
    check("key_ready_clr", 32'(key_ready_out), 32'd0);
    data_valid_in = 1'b1;
    step();
    check("key_load_single", 32'(key_exp_load_out), 32'd0);
    check("no_ready_kexp", 32'(data_ready_out), 32'd0);
    step();
    check("no_load_kexp", 32'(load_out), 32'd0);
    data_valid_in       = 1'b0;
    key_exp_finished_in = 1'b1;
    step();
    check("key_ready", 32'(key_ready_out), 32'd1);
    check("data_ready", 32'(data_ready_out), 32'd1);
  endtask

  task automatic start_block(input logic dec);
    for (int i = 0; i < 20 && !data_ready_out; i++) step();
    check("ready_before_blk", 32'(data_ready_out), 32'd1);
    for (int r = 0; r < 32; r++) rk_q.push_back(exp_idx(dec, r));
    lat_q.push_back(33);
    data_valid_in = 1'b1;
    decrypt_in    = dec;
    step();
    data_valid_in = 1'b0;
    decrypt_in    = 1'b0;
    check("load_pulse", 32'(load_out), 32'd1);
    check("ready_drop", 32'(data_ready_out), 32'd0);
    check("round_en_first", 32'(round_en_out), 32'd0);
  endtask

  task automatic run_block(input logic dec, input int hold);
    logic [4:0] rk_hold;
    start_block(dec);
    for (int i = 0; i < 40 && !data_valid_out; i++) step();
    check("dv_seen", 32'(data_valid_out), 32'd1);
    check("rk_left", 32'(rk_q.size()), 32'd0);
    check("rk_last", 32'(rk_idx_out), 32'(exp_idx(dec, 31)));
    rk_hold = rk_idx_out;
    data_valid_in = 1'b1;
    for (int k = 0; k < hold; k++) begin
      step();
      check("dv_hold", 32'(data_valid_out), 32'd1);
      check("no_ready_done", 32'(data_ready_out), 32'd0);
      check("no_load_done", 32'(load_out), 32'd0);
      check("rk_stable", 32'(rk_idx_out), 32'(rk_hold));
    end
    data_ready_in = 1'b1;
    step();
    data_ready_in = 1'b0;
    data_valid_in = 1'b0;
    check("dv_drop", 32'(data_valid_out), 32'd0);
    check("ready_back", 32'(data_ready_out), 32'd1);
    check("no_same_cycle_load", 32'(load_out), 32'd0);
    step();
    check("no_load_after", 32'(load_out), 32'd0);
  endtask

  task automatic expect_ignored(input string tag, input int n);
    data_valid_in = 1'b1;
    for (int k = 0; k < n; k++) begin
      step();
      check(tag, outs(), 32'd0);
    end
    data_valid_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sm4_enable_in = 1'b1;
    step(2);
    check("reset_outs", outs(), 32'd0);
    reset_n = 1'b1;
    step();
    check("idle_outs", outs(), 32'd0);
    expect_ignored("idle_no_key", 2);

    // Encrypt with long back-pressure, then decrypt
    load_key();
    run_block(1'b0, 10);
    run_block(1'b1, 0);

    // Enable dropped at round 15
    start_block(1'b0);
    for (int i = 0; i < 40 && !(round_en_out && rk_idx_out == 5'd15); i++) step();
    check("reach_rk15", 32'(rk_idx_out), 32'd15);
    sm4_enable_in = 1'b0;
    step();
    check("abort_outs", outs(), 32'd0);
    rk_q.delete();
    lat_q.delete();
    sm4_enable_in = 1'b1;
    expect_ignored("abort_no_key", 3);

    // Re-key, then key pulse ignored during ROUND and reset between edges
    load_key();
    run_block(1'b0, 1);
    start_block(1'b0);
    for (int i = 0; i < 40 && !(round_en_out && rk_idx_out == 5'd5); i++) step();
    user_key_valid_in = 1'b1;
    step();
    user_key_valid_in = 1'b0;
    check("kv_ignored_load", 32'(key_exp_load_out), 32'd0);
    check("kv_ignored_ready", 32'(key_ready_out), 32'd1);
    check("kv_ignored_round", 32'(round_en_out), 32'd1);
    for (int i = 0; i < 40 && !(round_en_out && rk_idx_out == 5'd10); i++) step();
    check("reach_rk10", 32'(rk_idx_out), 32'd10);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_reset_outs", outs(), 32'd0);
    step(2);
    reset_n = 1'b1;
    rk_q.delete();
    lat_q.delete();
    expect_ignored("post_reset_no_key", 3);

    load_key();
    run_block(1'b1, 2);

    check("rk_q_empty", 32'(rk_q.size()), 32'd0);
    check("lat_q_empty", 32'(lat_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sm4_round_ctrl.md
SM4_ROUND_CTRL -- requirements
Module: sm4_round_ctrl

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low (ports clk, reset_n).
REQ-002 clk  input  1  system clock, all state on rising edge.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 sm4_enable_in  input  1  global enable; low aborts all activity.
REQ-005 user_key_valid_in  input  1  one-cycle pulse: new user key present on the key bus.
REQ-006 key_exp_enable_out  output  1  enable to key_expansion, high from KEY_EXP entry until key invalidated.
REQ-007 key_exp_load_out  output  1  one-cycle pulse forwarded to key_expansion user_key_valid_in.
REQ-008 key_exp_finished_in  input  1  key_expansion done flag, level.
REQ-009 data_valid_in / data_ready_out  input / output  1 each  block-accept handshake.
REQ-010 decrypt_in  input  1  mode sampled with accepted block: 0 encrypt, 1 decrypt.
REQ-011 load_out  output  1  one-cycle pulse: round datapath loads input block.
REQ-012 round_en_out  output  1  round datapath advances one round.
REQ-013 rk_idx_out  output  5  round-key select (rk00..rk31) for the current round.
REQ-014 data_valid_out / data_ready_in  output / input  1 each  result handshake.
REQ-015 key_ready_out  output  1  expanded keys valid.

Function
REQ-016 States: IDLE, KEY_EXP, KEY_READY, ROUND, DONE.
REQ-017 IDLE/KEY_READY + user_key_valid_in & sm4_enable_in -> KEY_EXP; key_exp_load_out pulses same cycle (registered, next cycle); key_ready_out cleared.
REQ-018 KEY_EXP + key_exp_finished_in -> KEY_READY; key_ready_out=1.
REQ-019 data_ready_out=1 only in KEY_READY; valid&ready -> ROUND, load_out pulse, round counter=0, decrypt_in latched.
REQ-020 ROUND: round_en_out=1 every cycle; rk_idx_out=cnt (encrypt) or 31-cnt (decrypt); cnt 31 -> DONE, no wrap.
REQ-021 Latency: block accepted at edge T; rounds T+1..T+32; data_valid_out high from T+33.
REQ-022 DONE: data_valid_out held until data_ready_in; then KEY_READY (same-cycle new block not accepted).
REQ-023 user_key_valid_in in KEY_EXP, ROUND or DONE SHALL be ignored.
REQ-024 data_valid_in outside KEY_READY SHALL be ignored (no acceptance, no side effects).
REQ-025 sm4_enable_in low in any state -> IDLE next edge; all outputs 0; key invalidated.

Reset
REQ-026 reset_n low: state IDLE, counter 0, every output 0, decrypt latch 0, immediately and independent of clk.
REQ-027 Reset release mid-operation SHALL require a new key load before any block is accepted.

Configuration
REQ-028 SM4_DECRYPT_EN defined: decrypt_in honoured per REQ-020.
REQ-029 SM4_DECRYPT_EN undefined: decrypt_in ignored, rk_idx_out always = cnt; port retained.

Structure
REQ-030 Package sm4_ctrl_pkg: state enum, SM4_ROUNDS=32, RK_IDX_W=5.
REQ-031 One sub-module sm4_round_counter (5-bit counter, clear, enable, terminal flag at 31).

Verification
REQ-032 Key 0123456789abcdeffedcba9876543210 loaded -> key_exp_load_out one pulse, key_ready_out after finished; datapath model rk00=F12186F9, rk31=9124A012.
REQ-033 Encrypt plaintext 0123456789abcdeffedcba9876543210 -> rk_idx_out 0..31, data_valid_out at T+33, ciphertext 681EDF34D206965E86B3E94F536E4246.
REQ-034 Decrypt that ciphertext -> rk_idx_out 31..0, output 0123456789abcdeffedcba9876543210 (only with SM4_DECRYPT_EN).
REQ-035 data_ready_in held low 10 cycles in DONE -> data_valid_out stays high, no new block accepted, rk_idx_out stable.
REQ-036 sm4_enable_in dropped at round 15 -> IDLE next edge, outputs 0; subsequent data_valid_in ignored until re-key.
REQ-037 reset_n asserted mid-ROUND between edges -> outputs 0 immediately; user_key_valid_in during ROUND ignored.
